// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings.
//   pll_lock    : rPLL LOCK, asynchronous to the sequencer clock
//   restart_req : single-cycle request to re-run the full sequence
//   pll_reset   : rPLL RESET, active high
//   sys_resetn  : active-low system reset to downstream logic
//   ready/fail  : high while in RUN / FAIL
//   retry_cnt   : retries used in the current sequence
//   state       : current state encoding, for debug
// master = the sequencer, slave = the PLL / SoC side.
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       restart_req;
  logic       pll_reset;
  logic       sys_resetn;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  modport master (
    input  pll_lock, restart_req,
    output pll_reset, sys_resetn, ready, fail, retry_cnt, state
  );

  modport slave (
    output pll_lock, restart_req,
    input  pll_reset, sys_resetn, ready, fail, retry_cnt, state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Power-up and lock-supervision controller for the core-clock rPLL.
// Pulses pll_reset, qualifies the synchronized LOCK, and releases
// sys_resetn only after lock has been stable for LOCK_STABLE_CYCLES.
// Lock timeouts retry the PLL reset up to MAX_RETRIES times, then FAIL.
// Ports:
//   clk    : reference clock, all logic on its rising edge
//   resetn : asynchronous active-low reset
//   bus    : master side of pll_reset_sequencer_if (see that file)
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  pll_reset_sequencer_if.master bus
);

  localparam int MAXC0 = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                         RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAXC  = (MAXC0 > LOCK_TIMEOUT_CYCLES) ? MAXC0 : LOCK_TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [1:0]    lock_sync;
  logic          lock_s;
  logic          pll_reset_q, sys_resetn_q, ready_q, fail_q;

  // Two-stage synchronizer for the asynchronous LOCK input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lock_sync <= 2'b00;
    else         lock_sync <= {lock_sync[0], bus.pll_lock};
  end
  assign lock_s = lock_sync[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_reset_q  <= 1'b1;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      // Outputs are decoded from the next state so they move with state.
      pll_reset_q  <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_resetn_q <= (state_d == S_RUN);
      ready_q      <= (state_d == S_RUN);
      fail_q       <= (state_d == S_FAIL);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (bus.restart_req) begin
      // Restart outranks every other transition, including a timeout.
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STABLE: begin
          // A lock drop here is chatter: restart the timeout, not a retry.
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
          end
        end
        S_FAIL: ;
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  assign bus.pll_reset  = pll_reset_q;
  assign bus.sys_resetn = sys_resetn_q;
  assign bus.ready      = ready_q;
  assign bus.fail       = fail_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with RST=4, STABLE=8,
// TIMEOUT=32, MAX_RETRIES=2. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, so each step() is one edge.
module tb_pll_reset_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // state, pll_reset, sys_resetn, ready, fail, retry_cnt
  task automatic chk_all(input string tag, input int st, input logic pr,
                         input logic sr, input logic rd, input logic fl, input int rc);
    chk({tag, ".state"},      {5'd0, bus.state},      8'(st));
    chk({tag, ".pll_reset"},  {7'd0, bus.pll_reset},  {7'd0, pr});
    chk({tag, ".sys_resetn"}, {7'd0, bus.sys_resetn}, {7'd0, sr});
    chk({tag, ".ready"},      {7'd0, bus.ready},      {7'd0, rd});
    chk({tag, ".fail"},       {7'd0, bus.fail},       {7'd0, fl});
    chk({tag, ".retry_cnt"},  {4'd0, bus.retry_cnt},  8'(rc));
  endtask

  initial begin
    bus.pll_lock    = 1'b0;
    bus.restart_req = 1'b0;
    #1 resetn = 1'b0;
    #1 chk_all("reset_async", 0, 1, 0, 0, 0, 0);
    step(3);
    chk_all("reset_held", 0, 1, 0, 0, 0, 0);
    resetn = 1'b1;

    // 1. Nominal bring-up
    step(3); chk_all("t1_pulse", 0, 1, 0, 0, 0, 0);
    step(1); chk_all("t1_wait", 1, 0, 0, 0, 0, 0);
    step(6); bus.pll_lock = 1'b1;
    step(2); chk("t1_sync_wait", {5'd0, bus.state}, 8'd1);
    step(1); chk_all("t1_stable", 2, 0, 0, 0, 0, 0);
    step(7); chk_all("t1_stable_end", 2, 0, 0, 0, 0, 0);
    step(1); chk_all("t1_run", 3, 0, 1, 1, 0, 0);

    // 5. Lock loss in RUN
    bus.pll_lock = 1'b0;
    step(2); chk_all("t5_still_run", 3, 0, 1, 1, 0, 0);
    step(1); chk_all("t5_drop", 0, 1, 0, 0, 0, 0);
    step(3); chk_all("t5_pulse", 0, 1, 0, 0, 0, 0);
    step(1); chk_all("t5_wait", 1, 0, 0, 0, 0, 0);
    bus.pll_lock = 1'b1;
    step(3); chk("t5_stable", {5'd0, bus.state}, 8'd2);

    // 2. Chatter: lock_s low when stable count is 5
    step(3); bus.pll_lock = 1'b0;
    step(1); bus.pll_lock = 1'b1;
    step(1); chk("t2_cnt5", {5'd0, bus.state}, 8'd2);
    step(1); chk_all("t2_back_wait", 1, 0, 0, 0, 0, 0);
    step(1); chk_all("t2_restable", 2, 0, 0, 0, 0, 0);
    step(7); chk_all("t2_stable_end", 2, 0, 0, 0, 0, 0);
    step(1); chk_all("t2_run", 3, 0, 1, 1, 0, 0);

    // 3. Timeout and retries
    bus.pll_lock = 1'b0; bus.restart_req = 1'b1;
    step(1); bus.restart_req = 1'b0;
    chk_all("t3_restart", 0, 1, 0, 0, 0, 0);
    step(3); chk("t3_p0", {5'd0, bus.state}, 8'd0);
    step(1); chk_all("t3_w0", 1, 0, 0, 0, 0, 0);
    step(31); chk_all("t3_w0_end", 1, 0, 0, 0, 0, 0);
    step(1); chk_all("t3_retry1", 0, 1, 0, 0, 0, 1);
    step(3); chk("t3_p1", {5'd0, bus.state}, 8'd0);
    step(1); chk("t3_w1", {5'd0, bus.state}, 8'd1);
    step(31); chk_all("t3_w1_end", 1, 0, 0, 0, 0, 1);
    step(1); chk_all("t3_retry2", 0, 1, 0, 0, 0, 2);
    step(4); chk("t3_w2", {5'd0, bus.state}, 8'd1);
    step(31); chk_all("t3_w2_end", 1, 0, 0, 0, 0, 2);
    step(1); chk_all("t3_fail", 4, 1, 0, 0, 1, 2);
    step(5); chk_all("t3_fail_hold", 4, 1, 0, 0, 1, 2);

    // 4. Recovery from FAIL
    bus.restart_req = 1'b1;
    step(1); bus.restart_req = 1'b0; bus.pll_lock = 1'b1;
    chk_all("t4_restart", 0, 1, 0, 0, 0, 0);
    step(4); chk("t4_wait", {5'd0, bus.state}, 8'd1);
    step(1); chk("t4_stable", {5'd0, bus.state}, 8'd2);
    step(8); chk_all("t4_run", 3, 0, 1, 1, 0, 0);

    // 6b. restart_req coincident with a timeout, then restart mid-pulse
    bus.pll_lock = 1'b0; bus.restart_req = 1'b1;
    step(1); bus.restart_req = 1'b0;
    step(4); chk("t6_wait", {5'd0, bus.state}, 8'd1);
    step(31); chk_all("t6_to_edge", 1, 0, 0, 0, 0, 0);
    bus.restart_req = 1'b1;
    step(1); bus.restart_req = 1'b0;
    chk_all("t6_restart_prio", 0, 1, 0, 0, 0, 0);
    step(2); bus.restart_req = 1'b1;
    step(1); bus.restart_req = 1'b0;
    step(3); chk_all("t6_pulse_restart", 0, 1, 0, 0, 0, 0);
    step(1); chk("t6_wait2", {5'd0, bus.state}, 8'd1);

    // 6a. async reset mid-STABLE
    bus.pll_lock = 1'b1;
    step(3); chk("t6_stable", {5'd0, bus.state}, 8'd2);
    step(2);
    resetn = 1'b0;
    #2 chk_all("t6_async_rst", 0, 1, 0, 0, 0, 0);
    step(1); resetn = 1'b1;
    step(3); chk_all("t6_re_pulse", 0, 1, 0, 0, 0, 0);
    step(1); chk("t6_re_wait", {5'd0, bus.state}, 8'd1);
    step(1); chk("t6_re_stable", {5'd0, bus.state}, 8'd2);
    step(8); chk_all("t6_re_run", 3, 0, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
